// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: InstrMem address/data pair plus the IF/ID pipeline register outputs.
// The master side is the fetch stage and the slave side is the memory/decode consumer.
interface fetch_stage_if;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [9:0]  ifid_pc_plus1;
    logic        ifid_valid;

    modport master (
        output imem_addr,
        input  imem_instr,
        output ifid_instr,
        output ifid_pc_plus1,
        output ifid_valid
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  ifid_instr,
        input  ifid_pc_plus1,
        input  ifid_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses InstrMem and fills the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetched-instruction and stall-cycle counters.
module fetch_stage #(
    parameter logic [9:0]  RESET_PC = 10'd0,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [9:0]    branch_target,
    input  logic          jump,
    input  logic [9:0]    jump_target,
    fetch_stage_if.master bus,
    output logic          running
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stalls
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [9:0]  pc;
    logic [9:0]  pc_next_seq;
    logic        redirect;
    logic [9:0]  redirect_pc;

    // The branch is older than the jump in the pipeline, so it takes precedence.
    assign redirect    = branch_taken | jump;
    assign redirect_pc = branch_taken ? branch_target : jump_target;
    assign pc_next_seq = pc + 10'd1;

    assign bus.imem_addr = pc;

    // NOTE: every register here is written with <= so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            running           <= 1'b0;
            pc                <= RESET_PC;
            bus.ifid_instr    <= NOP_WORD;
            bus.ifid_pc_plus1 <= 10'd0;
            bus.ifid_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The start edge only arms the FSM; the first capture is one edge later.
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        pc                <= redirect_pc;
                        bus.ifid_instr    <= NOP_WORD;
                        bus.ifid_pc_plus1 <= 10'd0;
                        bus.ifid_valid    <= 1'b0;
                    end else if (!stall) begin
                        pc                <= pc_next_seq;
                        bus.ifid_instr    <= bus.imem_instr;
                        bus.ifid_pc_plus1 <= pc_next_seq;
                        bus.ifid_valid    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_edge;
    logic stall_edge;

    assign fetch_edge = (state == RUN) && !redirect && !stall;
    assign stall_edge = (state == RUN) && !redirect && stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stalls  <= 32'd0;
        end else begin
            if (fetch_edge) perf_fetched <= perf_fetched + 32'd1;
            if (stall_edge) perf_stalls  <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: a behavioural model pushes the expected
// post-edge state per clock and an independent monitor compares it on the falling edge.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [9:0] branch_target = 10'd0;
    logic       jump = 1'b0;
    logic [9:0] jump_target = 10'd0;
    logic       running;

    fetch_stage_if bus ();

    // InstrMem model: word at address A is 0x1000_0000 + A.
    assign bus.imem_instr = 32'h1000_0000 + {22'd0, bus.imem_addr};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .bus           (bus),
        .running       (running)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] instr;
        logic [9:0]  pc1;
        logic        valid;
        logic        run;
        logic [31:0] fetched;
        logic [31:0] stalls;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [9:0]  m_pc;
    logic [31:0] m_instr;
    logic [9:0]  m_pc1;
    logic        m_valid;
    logic        m_run;
    logic [31:0] m_fetched;
    logic [31:0] m_stalls;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    task automatic model_reset();
        m_pc      = 10'd0;
        m_instr   = 32'h0;
        m_pc1     = 10'd0;
        m_valid   = 1'b0;
        m_run     = 1'b0;
        m_fetched = 32'd0;
        m_stalls  = 32'd0;
    endtask

    // Spec rules for one rising edge, using the inputs held during the preceding cycle.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (start) m_run = 1'b1;
        end else if (branch_taken || jump) begin
            m_pc    = branch_taken ? branch_target : jump_target;
            m_instr = 32'h0;
            m_pc1   = 10'd0;
            m_valid = 1'b0;
        end else if (stall) begin
            m_stalls = m_stalls + 32'd1;
        end else begin
            m_instr   = mem_word(m_pc);
            m_pc      = m_pc + 10'd1;
            m_pc1     = m_pc;
            m_valid   = 1'b1;
            m_fetched = m_fetched + 32'd1;
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pc      = m_pc;
        e.instr   = m_instr;
        e.pc1     = m_pc1;
        e.valid   = m_valid;
        e.run     = m_run;
        e.fetched = m_fetched;
        e.stalls  = m_stalls;
        return e;
    endfunction

    task automatic do_edge(input logic s, input logic st, input logic br, input logic [9:0] bt,
                           input logic j, input logic [9:0] jt);
        start         = s;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        @(posedge clk);
        model_step();
        q.push_back(snap());
        #1;
        start        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
    endtask

    task automatic seq_edge();
        do_edge(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
    endtask

    // Asynchronous reset asserted between edges; checked before the next clock edge.
    task automatic async_reset(input int cycles);
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("arst_addr",    64'(bus.imem_addr),  64'd0);
        check("arst_valid",   64'(bus.ifid_valid), 64'd0);
        check("arst_instr",   64'(bus.ifid_instr), 64'd0);
        check("arst_running", 64'(running),        64'd0);
        repeat (cycles) seq_edge();
        rst_n = 1'b1;
    endtask

    // Monitor: compares the DUT against the oldest expectation on each falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("imem_addr",     64'(bus.imem_addr),     64'(e.pc));
            check("ifid_instr",    64'(bus.ifid_instr),    64'(e.instr));
            check("ifid_pc_plus1", 64'(bus.ifid_pc_plus1), 64'(e.pc1));
            check("ifid_valid",    64'(bus.ifid_valid),    64'(e.valid));
            check("running",       64'(running),           64'(e.run));
`ifdef FETCH_PERF_CNT_EN
            check("perf_fetched",  64'(perf_fetched),      64'(e.fetched));
            check("perf_stalls",   64'(perf_stalls),       64'(e.stalls));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset held for two cycles, then idle with ignored noise on control inputs.
        rst_n = 1'b0;
        seq_edge();
        seq_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_edge(1'b0, i[0], i[1], 10'd50, i[2], 10'd60);
            check("idle_addr",    64'(bus.imem_addr),  64'd0);
            check("idle_running", 64'(running),        64'd0);
            check("idle_valid",   64'(bus.ifid_valid), 64'd0);
        end

        // Start then sequential fetch
        do_edge(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
        check("start_running", 64'(running),        64'd1);
        check("start_valid",   64'(bus.ifid_valid), 64'd0);
        check("start_addr",    64'(bus.imem_addr),  64'd0);
        seq_edge();
        check("seq1_addr",  64'(bus.imem_addr),  64'd1);
        check("seq1_instr", 64'(bus.ifid_instr), 64'h1000_0000);
        seq_edge();
        check("seq2_addr",  64'(bus.imem_addr),  64'd2);
        seq_edge();
        check("seq3_addr",  64'(bus.imem_addr),     64'd3);
        check("seq3_instr", 64'(bus.ifid_instr),    64'h1000_0002);
        check("seq3_pc1",   64'(bus.ifid_pc_plus1), 64'd3);
        check("seq3_valid", 64'(bus.ifid_valid),    64'd1);
        seq_edge();
        seq_edge();
        check("pre_stall_addr", 64'(bus.imem_addr), 64'd5);

        // Stall for three edges
        for (int i = 0; i < 3; i++) begin
            do_edge(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
            check("stall_addr",  64'(bus.imem_addr),  64'd5);
            check("stall_instr", 64'(bus.ifid_instr), 64'h1000_0004);
        end
        seq_edge();
        check("unstall_addr",  64'(bus.imem_addr),  64'd6);
        check("unstall_instr", 64'(bus.ifid_instr), 64'h1000_0005);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stalls_3", 64'(perf_stalls),  64'd3);
        check("perf_fetch_6",  64'(perf_fetched), 64'd6);
`endif

        // Redirect priority: branch beats jump and stall
        seq_edge();
        check("pre_redir_addr", 64'(bus.imem_addr), 64'd7);
        do_edge(1'b0, 1'b1, 1'b1, 10'd200, 1'b1, 10'd89);
        check("redir_addr",  64'(bus.imem_addr),  64'd200);
        check("redir_valid", 64'(bus.ifid_valid), 64'd0);
        check("redir_instr", 64'(bus.ifid_instr), 64'h0);
        seq_edge();
        check("post_redir_instr", 64'(bus.ifid_instr), 64'h1000_00C8);

        // PC wrap at 1023
        do_edge(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd1022);
        check("wrap_addr0", 64'(bus.imem_addr), 64'd1022);
        seq_edge();
        check("wrap_addr1", 64'(bus.imem_addr), 64'd1023);
        seq_edge();
        check("wrap_addr2", 64'(bus.imem_addr),     64'd0);
        check("wrap_instr", 64'(bus.ifid_instr),    64'h1000_03FF);
        check("wrap_pc1",   64'(bus.ifid_pc_plus1), 64'd0);
        seq_edge();
        check("wrap_addr3", 64'(bus.imem_addr), 64'd1);

        // Reset mid-run at PC=15, then no fetch without a new start
        do_edge(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd14);
        seq_edge();
        check("pre_rst_addr", 64'(bus.imem_addr), 64'd15);
        async_reset(2);
        for (int i = 0; i < 3; i++) begin
            seq_edge();
            check("post_rst_addr",  64'(bus.imem_addr),  64'd0);
            check("post_rst_valid", 64'(bus.ifid_valid), 64'd0);
        end

        // Randomised traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset(1 + $urandom_range(0, 2));
            end else begin
                do_edge($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 15) == 0, 10'($urandom),
                        $urandom_range(0, 11) == 0, 10'($urandom));
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
